// File: rtl/dense_mac_sequencer.sv
// rtl/dense_mac_sequencer.sv - sequenced N_IN x N_OUT dense layer over N_OUT parallel MAC lanes
//
// Captures an input vector, walks the external synchronous weight ROM one row
// per cycle, accumulates x[k]*w[k][j] in every lane, adds bias, floors to the
// layer fixed-point format with saturation and holds the result until taken.
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready   input vector handshake, in_data element i at [i*W +: W]
//   bias_vec            per-lane bias, static while busy
//   w_rd_en/w_addr      weight ROM read request (row index)
//   w_row               ROM data, one cycle after w_rd_en
//   out_valid/out_ready output vector handshake, out_data lane j at [j*W +: W]
//   busy                high whenever the sequencer is not idle
module dense_mac_sequencer #(
  parameter int N_IN  = 32,
  parameter int N_OUT = 5,
  parameter int W     = 18,
  parameter int NFRAC = 9,
  localparam int AW   = (N_IN > 1) ? $clog2(N_IN) : 1,
  localparam int ACCW = 2*W + $clog2(N_IN) + 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [N_IN*W-1:0]  in_data,
  input  logic [N_OUT*W-1:0] bias_vec,
  output logic               w_rd_en,
  output logic [AW-1:0]      w_addr,
  input  logic [N_OUT*W-1:0] w_row,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [N_OUT*W-1:0] out_data,
  output logic               busy
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  localparam logic signed [ACCW:0] SMAX = (ACCW+1)'(2**(W-1) - 1);
  localparam logic signed [ACCW:0] SMIN = -SMAX - 1;

  state_t                 state;
  logic [N_IN*W-1:0]      x_reg;
  logic signed [ACCW-1:0] acc [N_OUT];
  // w_rd_en/w_addr delayed by one cycle: tells which row is on w_row now
  logic                   rd_d1;
  logic [AW-1:0]          addr_d1;

  logic signed [W-1:0]    x_cur;
  logic signed [W-1:0]    w_lane  [N_OUT];
  logic signed [W-1:0]    b_lane  [N_OUT];
  logic signed [2*W-1:0]  prod    [N_OUT];
  logic signed [ACCW:0]   sum     [N_OUT];
  logic signed [ACCW:0]   shifted [N_OUT];
  logic [N_OUT*W-1:0]     fin;

  assign x_cur = x_reg[addr_d1*W +: W];

  always_comb begin
    fin = '0;
    for (int j = 0; j < N_OUT; j++) begin
      w_lane[j]  = w_row[j*W +: W];
      b_lane[j]  = bias_vec[j*W +: W];
      prod[j]    = x_cur * w_lane[j];
      // bias moved onto the accumulator's 2*NFRAC binary point before adding
      sum[j]     = (ACCW+1)'(acc[j]) + ((ACCW+1)'(b_lane[j]) <<< NFRAC);
      shifted[j] = sum[j] >>> NFRAC;
      if (shifted[j] > SMAX)
        fin[j*W +: W] = SMAX[W-1:0];
      else if (shifted[j] < SMIN)
        fin[j*W +: W] = SMIN[W-1:0];
      else
        fin[j*W +: W] = shifted[j][W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      busy      <= 1'b0;
      w_rd_en   <= 1'b0;
      w_addr    <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      x_reg     <= '0;
      rd_d1     <= 1'b0;
      addr_d1   <= '0;
      for (int j = 0; j < N_OUT; j++) acc[j] <= '0;
    end else begin
      rd_d1   <= w_rd_en;
      addr_d1 <= w_addr;
      if (rd_d1)
        for (int j = 0; j < N_OUT; j++) acc[j] <= acc[j] + ACCW'(prod[j]);
      case (state)
        IDLE: begin
          if (in_valid) begin
            x_reg    <= in_data;
            for (int j = 0; j < N_OUT; j++) acc[j] <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            w_rd_en  <= 1'b1;
            w_addr   <= '0;
            state    <= RUN;
          end
        end
        RUN: begin
          if (w_addr == AW'(N_IN - 1)) begin
            w_rd_en <= 1'b0;
            state   <= DRAIN;
          end else begin
            w_addr <= w_addr + 1'b1;
          end
        end
        DRAIN: begin
          // rd_d1 low means the last row has already been accumulated
          if (!rd_d1) begin
            out_data  <= fin;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dense_mac_sequencer.sv
// tb/tb_dense_mac_sequencer.sv - self-checking bench for dense_mac_sequencer
`timescale 1ns/1ps
module tb_dense_mac_sequencer;
  localparam int N_IN = 32, N_OUT = 5, W = 18, NFRAC = 9, AW = 5;

  logic               clk, rst_n, in_valid, in_ready, w_rd_en, out_valid, out_ready, busy;
  logic [N_IN*W-1:0]  in_data;
  logic [N_OUT*W-1:0] bias_vec, w_row, out_data;
  logic [AW-1:0]      w_addr;

  dense_mac_sequencer #(.N_IN(N_IN), .N_OUT(N_OUT), .W(W), .NFRAC(NFRAC)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .bias_vec(bias_vec), .w_rd_en(w_rd_en), .w_addr(w_addr), .w_row(w_row),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy));

  typedef struct {
    int x; int w; bit pat; bit bp;
    int b [N_OUT];
    int e [N_OUT];
  } vec_t;

  vec_t tbl [8];
  logic [N_OUT*W-1:0] exp_q [$];
  int cmp_n = 0, fail_n = 0;
  int cur_w = 0;
  bit cur_pat = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int x_of(bit pat, int x, int i);
    return pat ? (i*37 - 500) : x;
  endfunction

  function automatic int w_of(bit pat, int w, int k, int j);
    return pat ? ((k*7 - j*13)*4 - 50) : w;
  endfunction

  // synchronous weight ROM
  always @(posedge clk)
    if (w_rd_en)
      for (int j = 0; j < N_OUT; j++) w_row[j*W +: W] <= W'(w_of(cur_pat, cur_w, int'(w_addr), j));

  task automatic chk(string nm, longint act, longint exp);
    cmp_n++;
    if (act != exp) begin
      fail_n++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic int model_lane(int idx, int j);
    longint s;
    s = longint'(tbl[idx].b[j]) * 512;
    for (int k = 0; k < N_IN; k++)
      s += longint'(x_of(tbl[idx].pat, tbl[idx].x, k)) * w_of(tbl[idx].pat, tbl[idx].w, k, j);
    s = s >>> NFRAC;
    if (s > 131071) s = 131071;
    if (s < -131072) s = -131072;
    return int'(s);
  endfunction

  task automatic load_inputs(int idx);
    cur_w   = tbl[idx].w;
    cur_pat = tbl[idx].pat;
    for (int i = 0; i < N_IN; i++) in_data[i*W +: W] = W'(x_of(tbl[idx].pat, tbl[idx].x, i));
    for (int j = 0; j < N_OUT; j++) bias_vec[j*W +: W] = W'(tbl[idx].b[j]);
  endtask

  task automatic run_vec(int idx);
    logic [N_OUT*W-1:0] expv, got;
    int edges, rd_n, nexp, addr_bad;
    bit seen;
    load_inputs(idx);
    for (int j = 0; j < N_OUT; j++) expv[j*W +: W] = W'(tbl[idx].e[j]);
    @(negedge clk);
    chk("in_ready_idle", in_ready, 1);
    in_valid = 1'b1;
    exp_q.push_back(expv);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = ~in_data;
    edges = 0; rd_n = 0; nexp = 0; addr_bad = 0; seen = 0;
    while (edges < 100) begin
      if (w_rd_en) begin
        if (int'(w_addr) != nexp) addr_bad++;
        nexp++;
        rd_n++;
      end
      if (out_valid) begin
        seen = 1;
        break;
      end
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    chk("out_valid_seen", seen, 1);
    chk("latency", edges, N_IN + 2);
    chk("rd_en_cycles", rd_n, N_IN);
    chk("addr_seq_errors", addr_bad, 0);
    if (seen) begin
      got  = out_data;
      expv = exp_q.pop_front();
      for (int j = 0; j < N_OUT; j++)
        chk($sformatf("vec%0d_lane%0d", idx, j), longint'($signed(got[j*W +: W])),
            longint'($signed(expv[j*W +: W])));
      chk("rd_en_low_done", w_rd_en, 0);
      chk("busy_done", busy, 1);
      if (tbl[idx].bp) begin
        for (int c = 0; c < 10; c++) begin
          in_valid = ~in_valid;
          @(posedge clk);
          @(negedge clk);
          chk("bp_out_valid", out_valid, 1);
          chk("bp_out_data", longint'(out_data != got), 0);
          chk("bp_in_ready", in_ready, 0);
        end
        in_valid = 1'b0;
      end
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
      chk("post_hs_out_valid", out_valid, 0);
      chk("post_hs_in_ready", in_ready, 1);
      chk("post_hs_busy", busy, 0);
      chk("post_hs_data_kept", longint'(out_data != got), 0);
    end
  endtask

  initial begin
    tbl[0].x = 512;     tbl[0].w = 512; tbl[0].pat = 0; tbl[0].bp = 0;
    tbl[0].b = '{0, 0, 0, 0, 0};            tbl[0].e = '{16384, 16384, 16384, 16384, 16384};
    tbl[1].x = 131071;  tbl[1].w = 512; tbl[1].pat = 0; tbl[1].bp = 1;
    tbl[1].b = '{0, 0, 0, 0, 0};            tbl[1].e = '{131071, 131071, 131071, 131071, 131071};
    tbl[2].x = -131072; tbl[2].w = 512; tbl[2].pat = 0; tbl[2].bp = 0;
    tbl[2].b = '{0, 0, 0, 0, 0};            tbl[2].e = '{-131072, -131072, -131072, -131072, -131072};
    tbl[3].x = 1;       tbl[3].w = 1;   tbl[3].pat = 0; tbl[3].bp = 0;
    tbl[3].b = '{0, 0, 0, 0, 0};            tbl[3].e = '{0, 0, 0, 0, 0};
    tbl[4].x = -1;      tbl[4].w = 1;   tbl[4].pat = 0; tbl[4].bp = 0;
    tbl[4].b = '{0, 0, 0, 0, 0};            tbl[4].e = '{-1, -1, -1, -1, -1};
    tbl[5].x = 0;       tbl[5].w = 512; tbl[5].pat = 0; tbl[5].bp = 0;
    tbl[5].b = '{-32, -33, -36, 42, 110};   tbl[5].e = '{-32, -33, -36, 42, 110};
    tbl[6].x = 256;     tbl[6].w = -512; tbl[6].pat = 0; tbl[6].bp = 0;
    tbl[6].b = '{3, 3, 3, 3, 3};            tbl[6].e = '{-8189, -8189, -8189, -8189, -8189};
    tbl[7].x = 0;       tbl[7].w = 0;   tbl[7].pat = 1; tbl[7].bp = 1;
    tbl[7].b = '{100, -200, 0, 7, -1};
    for (int j = 0; j < N_OUT; j++) tbl[7].e[j] = model_lane(7, j);

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0; bias_vec = '0; w_row = '0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_w_rd_en", w_rd_en, 0);
    chk("rst_w_addr", w_addr, 0);
    chk("rst_busy", busy, 0);
    chk("rst_out_data", longint'(out_data != '0), 0);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) run_vec(i);

    // abort a run partway through RUN; the result must not leak into the next vector
    load_inputs(0);
    @(negedge clk);
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (10) @(negedge clk);
    chk("pre_abort_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("abort_in_ready", in_ready, 1);
    chk("abort_out_valid", out_valid, 0);
    chk("abort_w_rd_en", w_rd_en, 0);
    chk("abort_w_addr", w_addr, 0);
    chk("abort_busy", busy, 0);
    chk("abort_out_data", longint'(out_data != '0), 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_vec(0);

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, fail_n);
    $finish;
  end
endmodule
